// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the mem_responder memory model.
// Optional build macro used by mem_responder: MEM_RESP_DUMP_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_BUSY = 2'd2
    } state_e;

    localparam int DEF_LATENCY   = 4;
    localparam int DEF_MEM_WORDS = 32768;
    localparam int DEF_LINES     = 8;

    // Addr[15:1] is the 15-bit word address.
    localparam int WORD_AW = 15;

    // Index width for a power-of-two line count (at least two lines).
    function automatic int idx_bits(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_bits(DEF_LINES);
    localparam int DEF_TAG_W = WORD_AW - DEF_IDX_W;

endpackage

// File: rtl/mem_resp_tag_store.sv
// Direct-mapped, one-word-per-line tag store: combinational lookup and a
// single synchronous update port (fill sets valid/tag/data, update writes
// data only). Valid bits clear on rst; tag and data arrays are not reset.
module mem_resp_tag_store #(
    parameter int LINES = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_hit,
    output logic [15:0]      lk_data,
    input  logic             upd_en,
    input  logic             upd_fill,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [15:0]      upd_data
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES];

    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_data = data_q[lk_idx];

    // Next valid vector: a fill marks its line valid.
    always_comb begin
        valid_d = valid_q;
        if (upd_en && upd_fill) begin
            valid_d[upd_idx] = 1'b1;
        end
    end

    // Valid bits are control state and are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays: tag only changes on fill, data on fill or write-hit update.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            data_q[upd_idx] <= upd_data;
            if (upd_fill) begin
                tag_q[upd_idx] <= upd_tag;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Responder side of the Rd/Wr/Addr/Done/Stall memory handshake: a word
// memory behind a direct-mapped, write-through, no-write-allocate cache.
// Read hits finish in the request cycle; read misses and writes finish
// LATENCY cycles after acceptance with Stall high while busy.
// Build macro MEM_RESP_DUMP_EN: when defined, createdump=1 on a clock edge
// prints the backing memory contents in hex (simulation only).
// Backing memory relies on the simulator's zero initial contents.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int LINES     = DEF_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int         IDX_W    = idx_bits(LINES);
    localparam int         TAG_W    = WORD_AW - IDX_W;
    localparam int         MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WORD_AW-1:0]  word_q, word_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                whit_q, whit_d;

    logic [15:0]         mem [MEM_WORDS];
    logic [MEM_AW-1:0]   mem_addr;
    logic [15:0]         mem_rdata;
    logic                mem_we;

    logic                lk_hit;
    logic [15:0]         lk_data;
    logic                upd_en;
    logic                upd_fill;
    logic [15:0]         upd_data;

    logic                req_any;
    logic                req_bad;

    // Word index wraps modulo the memory depth.
    assign mem_addr  = MEM_AW'(32'(word_q) % MEM_WORDS);
    assign mem_rdata = mem[mem_addr];

    assign req_any = Rd | Wr;
    assign req_bad = (Rd & Wr) | (req_any & Addr[0]);

    assign Stall = (state_q != IDLE) && !rst;

    mem_resp_tag_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk      (clk),
        .rst      (rst),
        .lk_idx   (Addr[IDX_W:1]),
        .lk_tag   (Addr[15:IDX_W+1]),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
        .upd_en   (upd_en),
        .upd_fill (upd_fill),
        .upd_idx  (word_q[IDX_W-1:0]),
        .upd_tag  (word_q[WORD_AW-1:IDX_W]),
        .upd_data (upd_data)
    );

    // Handshake FSM: request decode in IDLE, countdown while busy.
    // Everything is suppressed during rst so an aborted request never
    // signals Done nor commits to memory or the tag store.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        whit_d   = whit_q;
        DataOut  = 16'h0000;
        Done     = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        mem_we   = 1'b0;
        upd_en   = 1'b0;
        upd_fill = 1'b0;
        upd_data = wdata_q;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req_bad) begin
                        Done = 1'b1;
                        err  = 1'b1;
                    end else if (Rd) begin
                        if (lk_hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = lk_data;
                        end else begin
                            word_d  = Addr[15:1];
                            cnt_d   = CNT_LOAD;
                            state_d = RD_MISS;
                        end
                    end else if (Wr) begin
                        word_d  = Addr[15:1];
                        wdata_d = DataIn;
                        whit_d  = lk_hit;
                        cnt_d   = CNT_LOAD;
                        state_d = WR_BUSY;
                    end
                end
                RD_MISS: begin
                    if (cnt_q == 4'd0) begin
                        Done     = 1'b1;
                        DataOut  = mem_rdata;
                        upd_en   = 1'b1;
                        upd_fill = 1'b1;
                        upd_data = mem_rdata;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                WR_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        Done     = 1'b1;
                        CacheHit = whit_q;
                        mem_we   = 1'b1;
                        upd_en   = whit_q;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields captured at accept; meaningless until then, so no reset.
    always_ff @(posedge clk) begin
        word_q  <= word_d;
        wdata_q <= wdata_d;
        whit_q  <= whit_d;
    end

    // Backing memory write at the Done edge of a write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= wdata_q;
        end
    end

`ifdef MEM_RESP_DUMP_EN
    // Simulation-only snapshot of the backing memory.
    always @(posedge clk) begin
        if (createdump) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                $display("%04h", mem[i]);
            end
        end
    end
`else
    logic unused_createdump;
    assign unused_createdump = createdump;
`endif

endmodule
